tlc_chain_streamer: RTL

- Parametrised successor to the fixed 4-channel, 769-bit LED-driver shifter.
- Serialises one control frame, then a continuous stream of grayscale frames, to NUM_CH daisy-chained driver channels over shared SCLK/LAT.
- Grayscale frames arrive over a valid/ready handshake and are double-buffered; the last frame is repeated when none is pending.
- Control is re-sent after reset, every CTRL_REFRESH grayscale frames, or on request. Sits between the frame source and the driver pins; GSCLK stays in the PLL.

---
 rtl/tlc_chain_streamer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tlc_chain_streamer.sv
// tlc_chain_streamer: daisy-chain LED driver serialiser with control refresh and double-buffered grayscale frames
module tlc_chain_streamer #(
   parameter int NUM_CH       = 4,
   parameter int LATCH_SIZE   = 769,
   parameter int SCLK_DIV     = 1,
   parameter int LAT_WIDTH    = 1,
   parameter int CTRL_REFRESH = 10
) (
   input  logic                         CLK_10M,
   input  logic                         RESET,
   input  logic                         ENABLE,
   input  logic [LATCH_SIZE-1:0]        CTRL_DATA,
   input  logic                         FORCE_CTRL,
   input  logic [NUM_CH*LATCH_SIZE-1:0] GS_DATA,
   input  logic                         GS_VALID,
   output logic                         GS_READY,
   output logic [NUM_CH-1:0]            SDOs,
   output logic                         SCLK,
   output logic                         LAT,
   output logic                         BUSY,
   output logic                         CTRL_PHASE,
   output logic                         FRAME_DONE
);
   localparam int IW   = LATCH_SIZE > 1 ? $clog2(LATCH_SIZE) : 1;
   localparam int MAXC = SCLK_DIV > LAT_WIDTH ? SCLK_DIV : LAT_WIDTH;
   localparam int CW   = $clog2(MAXC + 1);
   localparam int RW   = CTRL_REFRESH > 0 ? $clog2(CTRL_REFRESH + 1) : 1;

   typedef enum logic [2:0] {IDLE, DECIDE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

   state_t                                  state_q;
   logic [CW-1:0]                           cnt_q;
   logic [IW-1:0]                           idx_q;
   logic [RW-1:0]                           ref_q, ref_d;
   logic [NUM_CH-1:0][LATCH_SIZE-1:0]       sh_q;
   logic [NUM_CH*LATCH_SIZE-1:0]            act_q, pend_q, gs_sel_d;
   logic                                    pend_full_q, ctrl_pend_q;
   logic                                    sclk_q, lat_q, busy_q, ctrl_phase_q, done_q;

   // Next refresh count and the grayscale frame a DECIDE would pick (fresh pending data wins over a repeat)
   always_comb begin
      ref_d    = ref_q + RW'(1);
      gs_sel_d = pend_full_q ? pend_q : act_q;
   end

   // Each channel's serial output is the MSB of its own shift register, so SDO is a plain flop output
   always_comb begin
      SDOs = '0;
      for (int c = 0; c < NUM_CH; c++) SDOs[c] = sh_q[c][LATCH_SIZE-1];
   end

   assign GS_READY   = ~pend_full_q;
   assign SCLK       = sclk_q;
   assign LAT        = lat_q;
   assign BUSY       = busy_q;
   assign CTRL_PHASE = ctrl_phase_q;
   assign FRAME_DONE = done_q;

   // Frame sequencer, buffers and registered pin outputs
   always_ff @(posedge CLK_10M or posedge RESET) begin
      if (RESET) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         ref_q        <= '0;
         sh_q         <= '0;
         act_q        <= '0;
         pend_q       <= '0;
         pend_full_q  <= 1'b0;
         ctrl_pend_q  <= 1'b1;
         sclk_q       <= 1'b0;
         lat_q        <= 1'b0;
         busy_q       <= 1'b0;
         ctrl_phase_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (GS_VALID && !pend_full_q) begin
            pend_q      <= GS_DATA;
            pend_full_q <= 1'b1;
         end
         case (state_q)
            IDLE: if (ENABLE) begin
               state_q <= DECIDE;
               busy_q  <= 1'b1;
            end
            DECIDE: if (!ENABLE) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end else begin
               if (ctrl_pend_q) begin
                  sh_q         <= {NUM_CH{CTRL_DATA}};
                  ctrl_pend_q  <= 1'b0;
                  ctrl_phase_q <= 1'b1;
                  ref_q        <= '0;
               end else begin
                  sh_q         <= gs_sel_d;
                  ctrl_phase_q <= 1'b0;
                  if (pend_full_q) begin
                     act_q       <= pend_q;
                     pend_full_q <= 1'b0;
                  end
                  if (CTRL_REFRESH != 0) begin
                     ref_q <= ref_d;
                     if (ref_d == RW'(CTRL_REFRESH)) ctrl_pend_q <= 1'b1;
                  end
               end
               idx_q   <= IW'(LATCH_SIZE - 1);
               cnt_q   <= '0;
               sclk_q  <= 1'b0;
               state_q <= SHIFT_LO;
            end
            SHIFT_LO: if (cnt_q == CW'(SCLK_DIV - 1)) begin
               cnt_q   <= '0;
               sclk_q  <= 1'b1;
               state_q <= SHIFT_HI;
            end else cnt_q <= cnt_q + CW'(1);
            SHIFT_HI: if (cnt_q == CW'(SCLK_DIV - 1)) begin
               cnt_q  <= '0;
               sclk_q <= 1'b0;
               if (idx_q == '0) begin
                  lat_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= LATCH;
               end else begin
                  idx_q   <= idx_q - IW'(1);
                  for (int c = 0; c < NUM_CH; c++) sh_q[c] <= sh_q[c] << 1;
                  state_q <= SHIFT_LO;
               end
            end else cnt_q <= cnt_q + CW'(1);
            LATCH: if (cnt_q == CW'(LAT_WIDTH - 1)) begin
               cnt_q   <= '0;
               lat_q   <= 1'b0;
               state_q <= DECIDE;
            end else cnt_q <= cnt_q + CW'(1);
            default: state_q <= IDLE;
         endcase
         if (FORCE_CTRL) ctrl_pend_q <= 1'b1;
      end
   end
endmodule
